// File: rtl/time_counter.sv
// Time-of-day counter with a one-second prescaler and a four-state set mode
// (RUN, SET_HOUR, SET_MIN, SET_SEC). All outputs come straight from registers.
module time_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       day_pulse
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          day_q, day_d;
  logic          tick;

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      presc_q <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      day_q   <= day_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    day_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d = '0;
              if (hour_q == 6'd23) begin
                hour_d = '0;
                day_d  = 1'b1;
              end else begin
                hour_d = hour_q + 6'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_pulse) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_pulse)     state_d = SET_MIN;
        else if (inc_pulse) hour_d  = (hour_q == 6'd23) ? '0 : hour_q + 6'd1;
      end
      SET_MIN: begin
        if (mode_pulse)     state_d = SET_SEC;
        else if (inc_pulse) min_d   = (min_q == 6'd59) ? '0 : min_q + 6'd1;
      end
      SET_SEC: begin
        if (mode_pulse)     state_d = RUN;
        else if (inc_pulse) sec_d   = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
      end
      default: state_d = RUN;
    endcase

    // Any edge that ends outside RUN parks the prescaler at 0, so re-entering
    // RUN (or a tick coinciding with mode_pulse) restarts a full TICK_DIV period.
    if (state_d != RUN) presc_d = '0;
  end

  assign hour      = hour_q;
  assign minute    = min_q;
  assign second    = sec_q;
  assign mode      = state_q;
  assign day_pulse = day_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter at TICK_DIV=4: vector table, directed corner sequences,
// and random pulses checked against a seconds-of-day reference model.
module tb_time_counter;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       inc_pulse = 1'b0;
  logic [5:0] hour, minute, second;
  logic [1:0] mode;
  logic       day_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: time as seconds since midnight
  int  m_tod = 0;
  int  m_mode = 0;
  int  m_pre = 0;
  bit  m_day = 1'b0;

  time_counter #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .mode       (mode),
    .day_pulse  (day_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit r, m, i;
    int h, mi, s, md, day;
  } tv_t;

  tv_t vec[15];

  task automatic model_step(input bit r, input bit mp, input bit ip);
    int h, mi, s;
    if (!r) begin
      m_tod = 0; m_mode = 0; m_pre = 0; m_day = 1'b0;
    end else begin
      m_day = 1'b0;
      if (m_mode == 0) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          m_tod = (m_tod + 1) % 86400;
          if (m_tod == 0) m_day = 1'b1;
        end else begin
          m_pre = m_pre + 1;
        end
        if (mp) begin
          m_mode = 1;
          m_pre  = 0;
        end
      end else if (mp) begin
        m_mode = (m_mode + 1) % 4;
        m_pre  = 0;
      end else if (ip) begin
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        case (m_mode)
          1: h  = (h + 1) % 24;
          2: mi = (mi + 1) % 60;
          default: s = (s + 1) % 60;
        endcase
        m_tod = h * 3600 + mi * 60 + s;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit mp, input bit ip);
    reset_n = r; mode_pulse = mp; inc_pulse = ip;
    @(posedge clock);
    model_step(r, mp, ip);
    #1;
    mode_pulse = 1'b0; inc_pulse = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int h, input int mi, input int s,
                           input int md, input int day);
    check({tag, ".hour"},   int'(hour),      h);
    check({tag, ".minute"}, int'(minute),    mi);
    check({tag, ".second"}, int'(second),    s);
    check({tag, ".mode"},   int'(mode),      md);
    check({tag, ".day"},    int'(day_pulse), day);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, int'(m_day));
  endtask

  initial begin
    // r m i   h mi s md day
    vec[0]  = '{0,0,0, 0,0,0,0,0};
    vec[1]  = '{1,0,0, 0,0,0,0,0};
    vec[2]  = '{1,0,0, 0,0,0,0,0};
    vec[3]  = '{1,0,0, 0,0,0,0,0};
    vec[4]  = '{1,0,0, 0,0,1,0,0};
    vec[5]  = '{1,0,1, 0,0,1,0,0};
    vec[6]  = '{1,1,0, 0,0,1,1,0};
    vec[7]  = '{1,0,1, 1,0,1,1,0};
    vec[8]  = '{1,0,1, 2,0,1,1,0};
    vec[9]  = '{1,1,1, 2,0,1,2,0};
    vec[10] = '{1,0,1, 2,1,1,2,0};
    vec[11] = '{1,1,0, 2,1,1,3,0};
    vec[12] = '{1,0,1, 2,1,2,3,0};
    vec[13] = '{1,0,1, 2,1,3,3,0};
    vec[14] = '{0,0,1, 0,0,0,0,0};

    foreach (vec[k]) begin
      cyc(vec[k].r, vec[k].m, vec[k].i);
      check_all($sformatf("tbl%0d", k), vec[k].h, vec[k].mi, vec[k].s, vec[k].md, vec[k].day);
    end

    // First seconds after reset release: steps at edges 4, 8, 12
    cyc(0, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      cyc(1, 0, 0);
      check_all($sformatf("run%0d", n), 0, 0, n / TD, 0, 0);
    end

    // Set 23:59:59 then roll over midnight
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    for (int n = 0; n < 23; n++) cyc(1, 0, 1);
    cyc(1, 1, 0);
    for (int n = 0; n < 59; n++) cyc(1, 0, 1);
    cyc(1, 1, 0);
    for (int n = 0; n < 59; n++) cyc(1, 0, 1);
    check_all("set235959", 23, 59, 59, 3, 0);
    cyc(1, 1, 0);
    check_all("backrun", 23, 59, 59, 0, 0);
    for (int n = 1; n < TD; n++) begin
      cyc(1, 0, 0);
      check_all("prewrap", 23, 59, 59, 0, 0);
    end
    cyc(1, 0, 0);
    check_all("midnight", 0, 0, 0, 0, 1);
    cyc(1, 0, 0);
    check_all("daydrop", 0, 0, 0, 0, 0);

    // Hour wraps through 23 -> 0 under 25 increments
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    for (int n = 0; n < 25; n++) cyc(1, 0, 1);
    check_all("hour25", 1, 0, 0, 1, 0);

    // Minute 59 -> 0 without carry into hour, then mode+inc together
    cyc(1, 1, 0);
    for (int n = 0; n < 59; n++) cyc(1, 0, 1);
    check_all("min59", 1, 59, 0, 2, 0);
    cyc(1, 0, 1);
    check_all("minwrap", 1, 0, 0, 2, 0);
    cyc(1, 1, 1);
    check_all("modeinc", 1, 0, 0, 3, 0);

    // Hold in SET_MIN, then back to RUN: next second exactly TD edges later
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    for (int n = 0; n < 20; n++) cyc(1, 0, 0);
    check_all("holdmin", 0, 0, 0, 2, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    for (int n = 1; n < TD; n++) begin
      cyc(1, 0, 0);
      check("rearm.second", int'(second), 0);
    end
    cyc(1, 0, 0);
    check_all("rearm", 0, 0, 1, 0, 0);

    // Tick and mode_pulse on the same edge
    cyc(0, 0, 0);
    for (int n = 1; n < TD; n++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check_all("tickmode", 0, 0, 1, 1, 0);

    // Reset during SET_SEC with inc high
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    check_all("setsec", 0, 0, 2, 3, 0);
    cyc(0, 0, 1);
    check_all("rstsetsec", 0, 0, 0, 0, 0);

    // Random pulses against the reference model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(199) != 0), ($urandom_range(29) == 0), ($urandom_range(2) == 0));
      check_model("rand");
      if (hour > 6'd23 || minute > 6'd59 || second > 6'd59) begin
        vectors++;
        miscompares++;
        $display("FAIL range: got %0d:%0d:%0d, expected in-range value", hour, minute, second);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
